trivium_ctrl: RTL and testbench

- Sequencer for one Trivium keystream core: captures key/IV on a start request, loads the core, runs the 4×288-step warm-up, then packs keystream bits into WORD_W-bit words.
- Words leave on a valid/ready stream; the core is stalled under backpressure.
- Sits between the host/config logic and the bit-serial trivium core; it is the only driver of the core's load, enable and key/IV inputs.

---
 rtl/trivium_ctrl.sv | 159 +++++++++++++++
 tb/tb_trivium_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trivium_ctrl.sv
// Sequencer for one bit-serial Trivium core: key/IV capture, load, warm-up, word packing.
// Define TRIVIUM_CTRL_ABORT_EN to add the abort input that cancels any active run.
`timescale 1ns/1ps
module trivium_ctrl #(
  parameter int WORD_W = 8,
  parameter int WARMUP = 1152,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [79:0]       key,
  input  logic [79:0]       iv,
  input  logic [CNT_W-1:0]  nwords,
`ifdef TRIVIUM_CTRL_ABORT_EN
  input  logic              abort,
`endif
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] ks_word,
  output logic              ks_valid,
  input  logic              ks_ready,
  output logic [79:0]       core_key,
  output logic [79:0]       core_iv,
  output logic              core_load,
  output logic              core_en,
  input  logic              core_ks
);

  localparam int WCW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam int BCW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int PW  = (WORD_W > 1) ? (WORD_W - 1) : 1;
  localparam logic [WCW-1:0] WARM_LAST = WCW'(WARMUP - 1);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(WORD_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_WARMUP = 3'd2,
    S_RUN    = 3'd3,
    S_DRAIN  = 3'd4
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] nwords_r;
  logic [CNT_W-1:0] word_cnt_r;
  logic [WCW-1:0]   warm_cnt_r;
  logic [BCW-1:0]   bit_cnt_r;
  logic [PW-1:0]    pack_r;

  logic abort_s;
  logic hs_s;
  logic step_s;
  logic word_done_s;
  logic last_word_s;

`ifdef TRIVIUM_CTRL_ABORT_EN
  assign abort_s = abort && (state_r != S_IDLE);
`else
  assign abort_s = 1'b0;
`endif

  // The output slot is the packer's only stall point: a held word freezes the core.
  assign hs_s        = ks_valid && ks_ready;
  assign step_s      = (state_r == S_RUN) && (!ks_valid || ks_ready);
  assign word_done_s = step_s && (bit_cnt_r == BIT_LAST);
  assign last_word_s = word_done_s && (nwords_r != {CNT_W{1'b0}}) &&
                       ((word_cnt_r + CNT_W'(1'b1)) == nwords_r);

  assign busy      = (state_r != S_IDLE);
  assign core_load = (state_r == S_LOAD);
  assign core_en   = (state_r == S_WARMUP) || step_s;

  // Next-state decode; abort overrides every other transition.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_s = S_LOAD;
        else       state_s = S_IDLE;
      end
      S_LOAD:   state_s = S_WARMUP;
      S_WARMUP: begin
        if (warm_cnt_r == {WCW{1'b0}}) state_s = S_RUN;
        else                           state_s = S_WARMUP;
      end
      S_RUN: begin
        if (last_word_s) state_s = S_DRAIN;
        else             state_s = S_RUN;
      end
      S_DRAIN: begin
        if (hs_s) state_s = S_IDLE;
        else      state_s = S_DRAIN;
      end
      default:  state_s = S_IDLE;
    endcase
    if (abort_s) state_s = S_IDLE;
    else         state_s = state_s;
  end

  // State, capture registers, warm-up counter and done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= S_IDLE;
      core_key   <= 80'h0;
      core_iv    <= 80'h0;
      nwords_r   <= {CNT_W{1'b0}};
      warm_cnt_r <= {WCW{1'b0}};
      done       <= 1'b0;
    end else begin
      state_r <= state_s;
      done    <= (state_r == S_DRAIN) && hs_s && !abort_s;
      if ((state_r == S_IDLE) && start) begin
        core_key <= key;
        core_iv  <= iv;
        nwords_r <= nwords;
      end
      if (state_r == S_LOAD) begin
        warm_cnt_r <= WARM_LAST;
      end else if ((state_r == S_WARMUP) && (warm_cnt_r != {WCW{1'b0}})) begin
        warm_cnt_r <= warm_cnt_r - WCW'(1'b1);
      end
    end
  end

  // Packer, output word register and collected-word counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pack_r     <= {PW{1'b0}};
      bit_cnt_r  <= {BCW{1'b0}};
      word_cnt_r <= {CNT_W{1'b0}};
      ks_word    <= {WORD_W{1'b0}};
      ks_valid   <= 1'b0;
    end else if (abort_s) begin
      pack_r     <= {PW{1'b0}};
      bit_cnt_r  <= {BCW{1'b0}};
      word_cnt_r <= {CNT_W{1'b0}};
      ks_valid   <= 1'b0;
    end else begin
      if (state_r == S_LOAD) begin
        pack_r     <= {PW{1'b0}};
        bit_cnt_r  <= {BCW{1'b0}};
        word_cnt_r <= {CNT_W{1'b0}};
      end else if (word_done_s) begin
        pack_r     <= {PW{1'b0}};
        bit_cnt_r  <= {BCW{1'b0}};
        word_cnt_r <= word_cnt_r + CNT_W'(1'b1);
        ks_word    <= WORD_W'({pack_r, core_ks});
      end else if (step_s) begin
        pack_r    <= PW'({pack_r, core_ks});
        bit_cnt_r <= bit_cnt_r + BCW'(1'b1);
      end
      if (word_done_s) ks_valid <= 1'b1;
      else if (hs_s)   ks_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_trivium_ctrl.sv
// Self-checking bench for trivium_ctrl: behavioural Trivium core plus an independent keystream reference.
`timescale 1ns/1ps
module tb_trivium_ctrl;

  localparam int WORD_W     = 8;
  localparam int WARMUP     = 1152;
  localparam int CNT_W      = 16;
  localparam int EXP_FIRST  = 1161;   // WARMUP + WORD_W + 1 edges after the start edge
  localparam int UNB_CYCLES = 10000;
  localparam int UNB_WORDS  = 1105;   // words valid at cycles 1161 + 8*i <= 9999

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [79:0]       key_in = 80'h0;
  logic [79:0]       iv_in = 80'h0;
  logic [CNT_W-1:0]  nwords_in = '0;
  logic              abort = 1'b0;
  logic              busy, done, ks_valid, core_load, core_en, core_ks;
  logic              ks_ready = 1'b0;
  logic [WORD_W-1:0] ks_word;
  logic [79:0]       core_key, core_iv;

  int checks = 0;
  int errors = 0;
  logic [WORD_W-1:0] exp_q[$];
  logic [287:0]      st = '0;

  trivium_ctrl #(.WORD_W(WORD_W), .WARMUP(WARMUP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .key(key_in), .iv(iv_in), .nwords(nwords_in),
`ifdef TRIVIUM_CTRL_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .ks_word(ks_word), .ks_valid(ks_valid), .ks_ready(ks_ready),
    .core_key(core_key), .core_iv(core_iv), .core_load(core_load), .core_en(core_en),
    .core_ks(core_ks)
  );

  always #5 clk = ~clk;

  function automatic logic [287:0] tri_load(input logic [79:0] k, input logic [79:0] v);
    logic [287:0] s;
    s = '0;
    s[79:0]    = k;
    s[172:93]  = v;
    s[287:285] = 3'b111;
    return s;
  endfunction

  function automatic logic tri_z(input logic [287:0] s);
    return s[65] ^ s[92] ^ s[161] ^ s[176] ^ s[242] ^ s[287];
  endfunction

  function automatic logic [287:0] tri_step(input logic [287:0] s);
    logic t1, t2, t3;
    logic [287:0] n;
    t1 = s[65] ^ s[92] ^ (s[90] & s[91]) ^ s[170];
    t2 = s[161] ^ s[176] ^ (s[174] & s[175]) ^ s[263];
    t3 = s[242] ^ s[287] ^ (s[285] & s[286]) ^ s[68];
    n[92:0]    = {s[91:0], t3};
    n[176:93]  = {s[175:93], t1};
    n[287:177] = {s[286:177], t2};
    return n;
  endfunction

  // Behavioural core driven only by the controller's outputs.
  always @(posedge clk) begin
    if (core_load)    st <= tri_load(core_key, core_iv);
    else if (core_en) st <= tri_step(st);
  end
  assign core_ks = tri_z(st);

  task automatic ref_words(input logic [79:0] k, input logic [79:0] v, input int n);
    logic [287:0] s;
    logic [WORD_W-1:0] w;
    exp_q = {};
    s = tri_load(k, v);
    repeat (WARMUP) s = tri_step(s);
    for (int i = 0; i < n; i++) begin
      w = '0;
      for (int b = 0; b < WORD_W; b++) begin
        w = (w << 1) | WORD_W'(tri_z(s));
        s = tri_step(s);
      end
      exp_q.push_back(w);
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chk_quiet(input string name);
    chk(name, {56'h0, busy, done, ks_valid, core_load, core_en, |ks_word, |core_key, |core_iv}, 64'h0);
  endtask

  typedef struct {
    logic [79:0] key;
    logic [79:0] iv;
    int          nwords;
    int          rmode;      // 0: ready always high, 1: ready pattern 1,0,0,1
    int          gap;        // idle cycles before start; 0 = start in the current (done) cycle
    bit          poke;       // pulse start with another key during warm-up
    int          abort_word; // -1: no abort
    int          exp_first;
  } vec_t;

  function automatic logic ready_of(input int mode, input int k);
    logic [3:0] pat;
    pat = 4'b1001;
    if (mode == 0) return 1'b1;
    else           return pat[3 - (k % 4)];
  endfunction

  task automatic run_vec(input vec_t v);
    int k, got, first_k, en_cnt, warm_en, load_cnt, done_cnt, busy_low, done_k, budget, n_exp;
    bit finished, aborted, holding;
    logic [WORD_W-1:0] held;
    k = 0; got = 0; first_k = -1; en_cnt = 0; warm_en = 0; load_cnt = 0;
    done_cnt = 0; busy_low = 0; done_k = -1; finished = 0; aborted = 0; holding = 0;
    held = '0;
    n_exp  = (v.nwords == 0) ? UNB_WORDS : v.nwords;
    budget = (v.nwords == 0) ? UNB_CYCLES + 10 : EXP_FIRST + 40 * v.nwords + 100;
    ref_words(v.key, v.iv, n_exp);
    if (v.gap > 0) begin
      repeat (v.gap) @(posedge clk);
      #2;
    end
    key_in = v.key; iv_in = v.iv; nwords_in = CNT_W'(v.nwords); start = 1'b1; ks_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("load_after_start", {62'h0, core_load, core_en}, 64'h2);
    if (v.poke) key_in = ~v.key;
    while (!finished) begin
      ks_ready = ready_of(v.rmode, k);
      start = v.poke && (k == 300);
      #1;
      if (core_load) load_cnt++;
      if (core_en) en_cnt++;
      if (core_en && k >= 1 && k <= WARMUP) warm_en++;
      if (!busy && !done) busy_low++;
      if (ks_valid && first_k < 0) first_k = k;
      if (holding) begin
        chk("stall_hold", {55'h0, ks_valid, ks_word}, {55'h0, 1'b1, held});
        holding = 0;
      end
      if (done) begin
        done_cnt++;
        done_k = k;
        chk("busy_in_done", {63'h0, busy}, 64'h0);
        finished = 1;
      end else if (ks_valid && ks_ready) begin
        if (got < exp_q.size()) chk($sformatf("word%0d", got), {56'h0, ks_word}, {56'h0, exp_q[got]});
        else chk("extra_word", 64'(got), 64'(exp_q.size()));
        if (v.rmode == 0) chk("word_time", 64'(k), 64'(v.exp_first + WORD_W * got));
`ifdef TRIVIUM_CTRL_ABORT_EN
        if (got == v.abort_word) begin
          abort = 1'b1;
          @(posedge clk); #1;
          abort = 1'b0;
          chk("abort_outputs", {61'h0, ks_valid, busy, core_en}, 64'h0);
          done_cnt = 0;
          repeat (4) begin
            if (done) done_cnt++;
            @(posedge clk); #1;
          end
          chk("abort_no_done", 64'(done_cnt), 64'h0);
          aborted = 1;
          finished = 1;
        end
`endif
        got++;
      end else if (ks_valid) begin
        chk("stall_core_en", {63'h0, core_en}, 64'h0);
        held = ks_word;
        holding = 1;
      end
      if (v.nwords == 0 && k == UNB_CYCLES - 1) finished = 1;
      if (!finished && k > budget) begin
        chk("timeout", 64'(k), 64'(budget));
        finished = 1;
      end
      if (!finished) begin
        @(posedge clk); #1;
        k++;
      end
    end
    start = 1'b0;
    if (!aborted) begin
      chk("first_valid", 64'(first_k), 64'(v.exp_first));
      chk("load_once", 64'(load_cnt), 64'h1);
      chk("warm_en", 64'(warm_en), 64'(WARMUP));
      chk("busy_hold", 64'(busy_low), 64'h0);
      if (v.nwords != 0) begin
        chk("word_count", 64'(got), 64'(v.nwords));
        chk("done_once", 64'(done_cnt), 64'h1);
        chk("en_total", 64'(en_cnt), 64'(WARMUP + WORD_W * v.nwords));
        if (v.rmode == 0) chk("done_time", 64'(done_k), 64'(v.exp_first + WORD_W * (v.nwords - 1) + 1));
      end else begin
        chk("unb_words", 64'(got), 64'(UNB_WORDS));
        chk("unb_no_done", 64'(done_cnt), 64'h0);
      end
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    vec_t u;
    tbl.push_back('{80'h0, 80'h0, 4, 0, 2, 1'b0, -1, EXP_FIRST});
    tbl.push_back('{80'h0, 80'h0, 4, 1, 0, 1'b0, -1, EXP_FIRST});
    tbl.push_back('{80'h0123456789abcdef0123, 80'hfedcba9876543210fedc, 3, 0, 3, 1'b1, -1, EXP_FIRST});
    tbl.push_back('{80'h80000000000000000001, 80'h00000000000000000001, 1, 1, 0, 1'b0, -1, EXP_FIRST});
`ifdef TRIVIUM_CTRL_ABORT_EN
    tbl.push_back('{80'h0, 80'h0, 4, 0, 2, 1'b0, 1, EXP_FIRST});
    tbl.push_back('{80'h0, 80'h0, 1, 0, 0, 1'b0, -1, EXP_FIRST});
`endif

    repeat (3) @(posedge clk);
    #2;
    chk_quiet("reset_state");
    rst = 1'b1;
    @(posedge clk); #2;
    chk_quiet("idle_after_reset");

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

    u = '{80'h0, 80'h0, 0, 0, 2, 1'b0, -1, EXP_FIRST};
    run_vec(u);
    chk("unb_busy_end", {63'h0, busy}, 64'h1);
    rst = 1'b0;
    #1;
    chk_quiet("rst_unbounded");
    #2;
    rst = 1'b1;
    @(posedge clk); #2;

    key_in = 80'h0; iv_in = 80'h0; nwords_in = 16'd4; ks_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (601) @(posedge clk);
    #3;
    chk("warm_en_before_rst", {62'h0, busy, core_en}, 64'h3);
    rst = 1'b0;
    #1;
    chk_quiet("rst_in_warmup");
    #2;
    rst = 1'b1;
    @(posedge clk); #2;
    chk_quiet("idle_after_warm_rst");
    run_vec(tbl[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
